// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Conditions the raw board push-buttons before they reach the game
//   controller. Each channel gets a 2-flop synchronizer and then a
//   consecutive-sample debounce filter. The outputs are a clean level plus
//   one-cycle press and release pulses. Everything runs on the pixel clock.
//
// Ports
//   i_clk      pixel clock, the single clock domain
//   i_rst      synchronous reset, active-low (0 = reset)
//   i_btn      raw asynchronous buttons {rst,left,down,right,up}
//   o_level    debounced level, 1 = held
//   o_press    1-cycle pulse on a debounced 0->1 transition
//   o_release  1-cycle pulse on a debounced 1->0 transition
module btn_conditioner #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_press,
  output logic [NUM_BTN-1:0] o_release
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0]            s1_q, s2_q;
  logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_BTN-1:0]            level_q, level_d;
  logic [NUM_BTN-1:0]            press_q, press_d;
  logic [NUM_BTN-1:0]            release_q, release_d;

  // The pulses are computed on the same edge that flips the level. That way
  // each pulse coincides exactly with the first cycle of the new level.
  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      if (s2_q[k] == level_q[k]) begin
        // A mismatching run that is too short is thrown away here.
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_MAX) begin
        level_d[k]   = s2_q[k];
        cnt_d[k]     = '0;
        press_d[k]   = s2_q[k];
        release_d[k] = ~s2_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      s1_q      <= i_btn;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn;
  logic [NB-1:0] level, press, rel;

  int tests = 0;
  int fails = 0;
  int npress;

  btn_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn),
    .o_level(level), .o_press(press), .o_release(rel)
  );

  always #5 clk = ~clk;

  // One active edge, then settle. Outputs are sampled and inputs are driven
  // here, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with all buttons held, then re-qualification after release
    rst = 1'b0; btn = 5'h1F;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_level", level, 0);
      chk("rst_press", press, 0);
      chk("rst_release", rel, 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("rq_level_early", level, 0);
    tick();
    chk("rq_level", level, 5'h1F);
    chk("rq_press", press, 5'h1F);
    tick();
    chk("rq_press_gone", press, 0);

    // Drop everything so the next tests start from idle
    btn = 5'h00;
    for (int i = 0; i < 6; i++) tick();
    chk("all_release", rel, 5'h1F);
    chk("all_level0", level, 0);
    tick();
    chk("all_release_gone", rel, 0);

    // 2: clean press of up, then hold
    btn = 5'h01;
    for (int i = 0; i < 5; i++) tick();
    chk("up_level_early", level, 0);
    tick();
    chk("up_level", level, 5'h01);
    chk("up_press", press, 5'h01);
    tick();
    chk("up_press_gone", press, 0);
    npress = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (press != 0) npress++;
    end
    chk("up_hold_no_repeat", npress, 0);
    chk("up_hold_level", level, 5'h01);

    // 3: glitch of 3 cycles on down is rejected
    btn = 5'h05;
    for (int i = 0; i < 3; i++) tick();
    btn = 5'h01;
    npress = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (press[2] || level[2]) npress++;
    end
    chk("glitch_rejected", npress, 0);

    // 4: bounce on right, then stays high
    btn = 5'h03; tick();
    btn = 5'h01; tick();
    btn = 5'h03; tick();
    btn = 5'h01; tick();
    btn = 5'h03;
    npress = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (press[1]) npress++;
    end
    chk("bounce_level_early", level[1], 0);
    tick();
    chk("bounce_press", press, 5'h02);
    chk("bounce_level", level, 5'h03);
    if (press[1]) npress++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (press[1]) npress++;
    end
    chk("bounce_single_press", npress, 1);

    // 5: left pressed, then released
    btn = 5'h0B;
    for (int i = 0; i < 6; i++) tick();
    chk("left_press", press, 5'h08);
    tick();
    btn = 5'h03;
    for (int i = 0; i < 5; i++) tick();
    chk("left_rel_early", rel, 0);
    chk("left_level_held", level, 5'h0B);
    tick();
    chk("left_release", rel, 5'h08);
    chk("left_level0", level, 5'h03);
    chk("left_no_press", press, 0);
    tick();
    chk("left_release_gone", rel, 0);
    chk("left_level_stays0", level, 5'h03);

    // 6: simultaneous press of right+left from idle
    btn = 5'h00;
    for (int i = 0; i < 8; i++) tick();
    chk("idle_level", level, 0);
    btn = 5'h0A;
    for (int i = 0; i < 5; i++) tick();
    chk("sim_press_early", press, 0);
    tick();
    chk("sim_press", press, 5'h0A);
    chk("sim_level", level, 5'h0A);

    // reset mid-count: the count is lost and qualification restarts
    btn = 5'h00;
    for (int i = 0; i < 8; i++) tick();
    chk("sim_level0", level, 0);
    btn = 5'h0A;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_press", press, 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("restart_no_early", press, 0);
    chk("restart_level_early", level, 0);
    tick();
    chk("restart_press", press, 5'h0A);
    chk("restart_level", level, 5'h0A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
